ex_mem_stage: RTL
=================

// Module: ex_mem_stage
// PURPOSE
//  Execute stage plus EX/MEM pipeline register of the 5-stage PCPU. Consumes ex_* bundle from
//  the ID/EX register, computes ALU/shift/LUI/link result, and registers it with
//  store data and control into mem_* for the MEM stage. Also exports the unregistered EX result
//  and destination for ID-stage forwarding/load-use detection. Flush inserts a bubble.
// PARAMETERS
//  XLEN         32      datapath width; fixed at 32 for this ISA, kept for lint only
//  BUBBLE_INST  32'h0   value loaded into mem_inst on flush/reset (MIPS nop)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   reset, synchronous, active-high
//  CE             in   1   stage enable; 0 = hold all mem_* registers
//  flush          in   1   replace incoming instruction with bubble at next edge
//  ex_WMEM/WREG/JAL/M2REG/LUI/SHIFT/ALUIMM/RMEM  in  1 each  decoded controls from ID/EX
//  ex_ALU_Ctr     in   3   ALU op select
//  ex_FQ1, ex_FQ2 in   32  forwarded rs / rt operands
//  ex_EXT_imm16   in   32  extended immediate
//  ex_pc, ex_pc_p4, ex_inst in 32  PC, PC+4, instruction word
//  ex_nd          in   5   destination register number
//  ex_result      out  32  combinational EX result (forwarding path to ID)
//  ex_load_use    out  1   ex_RMEM & ex_WREG & (ex_nd!=0): load in EX, ID must stall
//  mem_WMEM/WREG/M2REG/RMEM out 1 registered controls
//  mem_nd         out  5   registered destination
//  mem_alu_out    out  32  registered ex_result (memory address or writeback value)
//  mem_store_data out  32  registered ex_FQ2
//  mem_pc, mem_inst out 32 registered ex_pc / ex_inst (debug, exception tracking)
// BEHAVIOUR
//  Operand select: A = ex_FQ1; B = ex_ALUIMM ? ex_EXT_imm16 : ex_FQ2.
//  ALU_Ctr: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOR, 110 SLT (signed), 111 SLTU.
//   ADD/SUB wrap modulo 2^32, no overflow trap; SLT/SLTU yield 32'h0/32'h1.
//  ex_SHIFT=1: shamt = ex_inst[10:6], operand ex_FQ2; ALU_Ctr 000 SLL, 001 SRL, 010 SRA,
//   other codes -> 32'h0. shamt 0 passes ex_FQ2 unchanged.
//  Result priority: ex_JAL -> ex_pc_p4; else ex_LUI -> {ex_EXT_imm16[15:0],16'h0};
//   else ex_SHIFT -> shifter; else ALU. ex_result driven purely combinationally, zero latency.
//  Register update priority each rising edge: rst > flush > CE > hold.
//   rst: all mem_* = 0 except mem_inst = BUBBLE_INST.
//   flush (regardless of CE): mem_WMEM,WREG,M2REG,RMEM = 0, mem_nd = 0, mem_inst = BUBBLE_INST;
//    mem_alu_out, mem_store_data, mem_pc load 0.
//   CE=1: all mem_* load from the EX bundle/ex_result; latency 1 cycle.
//   CE=0: all mem_* hold, including across any ex_* input changes.
//  Write to $0: mem_WREG forced 0 when ex_nd==0 (no writeback, no forwarding match).
//  ex_load_use is combinational, independent of CE/flush; ID owns the stall decision.
//  Reset mid-stream: next edge overrides CE/flush; first cycle after reset is a bubble.
// TESTING
//  1 ADD: FQ1=5, FQ2=7, ALU_Ctr=000, CE=1 -> ex_result=12 same cycle; mem_alu_out=12, mem_WREG=1 next edge.
//  2 Wrap/SLT: FQ1=32'hFFFF_FFFF, FQ2=1: ADD -> 0; SLT -> 1; SLTU -> 0.
//  3 Shift/LUI/JAL: inst[10:6]=4, FQ2=32'h8000_0000 SRA -> 32'hF800_0000; LUI imm=32'h1234 -> 32'h1234_0000;
//    JAL pc_p4=32'h0040_0008 with LUI=1 -> mem_alu_out=32'h0040_0008.
//  4 Hold/flush: CE=0 two cycles with changing inputs -> mem_* unchanged; flush=1 with CE=0 ->
//    controls 0, mem_inst=0 next edge.
//  5 $0 and load-use: WREG=1, nd=0 -> mem_WREG=0, ex_load_use=0; RMEM=1, WREG=1, nd=8 -> ex_load_use=1.
//  6 Reset: rst=1 during valid stream with CE=1, flush=1 -> all mem_* = 0 after edge; CE resumes next cycle.

Source files
------------

// File: rtl/ex_mem_stage.sv
// Execute stage of the 5-stage PCPU followed by the EX/MEM pipeline register.
// ex_result and ex_load_use are combinational taps for ID-stage forwarding and stall logic.
module ex_mem_stage #(
    parameter int          XLEN        = 32,
    parameter logic [31:0] BUBBLE_INST = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            CE,
    input  logic            flush,
    input  logic            ex_WMEM,
    input  logic            ex_WREG,
    input  logic            ex_JAL,
    input  logic            ex_M2REG,
    input  logic            ex_LUI,
    input  logic            ex_SHIFT,
    input  logic            ex_ALUIMM,
    input  logic            ex_RMEM,
    input  logic [2:0]      ex_ALU_Ctr,
    input  logic [XLEN-1:0] ex_FQ1,
    input  logic [XLEN-1:0] ex_FQ2,
    input  logic [XLEN-1:0] ex_EXT_imm16,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_pc_p4,
    input  logic [XLEN-1:0] ex_inst,
    input  logic [4:0]      ex_nd,
    output logic [XLEN-1:0] ex_result,
    output logic            ex_load_use,
    output logic            mem_WMEM,
    output logic            mem_WREG,
    output logic            mem_M2REG,
    output logic            mem_RMEM,
    output logic [4:0]      mem_nd,
    output logic [XLEN-1:0] mem_alu_out,
    output logic [XLEN-1:0] mem_store_data,
    output logic [XLEN-1:0] mem_pc,
    output logic [XLEN-1:0] mem_inst
);

    typedef struct packed {
        logic            wmem;
        logic            wreg;
        logic            m2reg;
        logic            rmem;
        logic [4:0]      nd;
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } mem_bundle_t;

    localparam mem_bundle_t BUBBLE = '{
        wmem: 1'b0, wreg: 1'b0, m2reg: 1'b0, rmem: 1'b0, nd: 5'd0,
        alu_out: '0, store_data: '0, pc: '0, inst: BUBBLE_INST
    };

    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] sh_res;
    logic [4:0]      shamt;
    logic            nd_nonzero;
    mem_bundle_t     nxt;
    mem_bundle_t     mem_q;

    assign op_b       = ex_ALUIMM ? ex_EXT_imm16 : ex_FQ2;
    assign shamt      = ex_inst[10:6];
    assign nd_nonzero = (ex_nd != 5'd0);

    always_comb begin
        alu_res = '0;
        case (ex_ALU_Ctr)
            3'b000: alu_res = ex_FQ1 + op_b;
            3'b001: alu_res = ex_FQ1 - op_b;
            3'b010: alu_res = ex_FQ1 & op_b;
            3'b011: alu_res = ex_FQ1 | op_b;
            3'b100: alu_res = ex_FQ1 ^ op_b;
            3'b101: alu_res = ~(ex_FQ1 | op_b);
            3'b110: alu_res = {{(XLEN-1){1'b0}}, $signed(ex_FQ1) < $signed(op_b)};
            3'b111: alu_res = {{(XLEN-1){1'b0}}, ex_FQ1 < op_b};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        sh_res = '0;
        case (ex_ALU_Ctr)
            3'b000:  sh_res = ex_FQ2 << shamt;
            3'b001:  sh_res = ex_FQ2 >> shamt;
            3'b010:  sh_res = $unsigned($signed(ex_FQ2) >>> shamt);
            default: sh_res = '0;
        endcase
    end

    always_comb begin
        if (ex_JAL)
            ex_result = ex_pc_p4;
        else if (ex_LUI)
            ex_result = {ex_EXT_imm16[15:0], 16'h0};
        else if (ex_SHIFT)
            ex_result = sh_res;
        else
            ex_result = alu_res;
    end

    assign ex_load_use = ex_RMEM & ex_WREG & nd_nonzero;

    // A write to $0 is squashed here so MEM/WB forwarding never matches $0.
    always_comb begin
        nxt            = BUBBLE;
        nxt.wmem       = ex_WMEM;
        nxt.wreg       = ex_WREG & nd_nonzero;
        nxt.m2reg      = ex_M2REG;
        nxt.rmem       = ex_RMEM;
        nxt.nd         = ex_nd;
        nxt.alu_out    = ex_result;
        nxt.store_data = ex_FQ2;
        nxt.pc         = ex_pc;
        nxt.inst       = ex_inst;
    end

    always_ff @(posedge clk) begin
        if (rst || flush)
            mem_q <= BUBBLE;
        else if (CE)
            mem_q <= nxt;
    end

    assign mem_WMEM       = mem_q.wmem;
    assign mem_WREG       = mem_q.wreg;
    assign mem_M2REG      = mem_q.m2reg;
    assign mem_RMEM       = mem_q.rmem;
    assign mem_nd         = mem_q.nd;
    assign mem_alu_out    = mem_q.alu_out;
    assign mem_store_data = mem_q.store_data;
    assign mem_pc         = mem_q.pc;
    assign mem_inst       = mem_q.inst;

endmodule
